// File: rtl/core_pkg.sv
// Shared core definitions: opcode constants, register/opcode widths and the
// pipeline sequencer state encoding.
package core_pkg;

    localparam int REG_W = 6;
    localparam int OPC_W = 7;

    localparam logic [OPC_W-1:0] OP_LDB  = 7'h11;
    localparam logic [OPC_W-1:0] OP_LDW  = 7'h12;
    localparam logic [OPC_W-1:0] OP_STB  = 7'h13;
    localparam logic [OPC_W-1:0] OP_STW  = 7'h14;
    localparam logic [OPC_W-1:0] OP_BEQ  = 7'h30;
    localparam logic [OPC_W-1:0] OP_JUMP = 7'h31;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2
    } seq_state_e;

    function automatic logic is_load(input logic [OPC_W-1:0] op);
        return (op == OP_LDB) || (op == OP_LDW);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags a load in X whose destination feeds a source the
// decode-stage instruction actually reads. Register 0 never creates a hazard.
module hazard_detect
    import core_pkg::*;
(
    input  logic [OPC_W-1:0] x_opcode_i,
    input  logic [REG_W-1:0] x_dst_reg_i,
    input  logic [REG_W-1:0] d_src_reg_1_i,
    input  logic [REG_W-1:0] d_src_reg_2_i,
    input  logic             d_uses_src_2_i,
    output logic             lu_o
);

    logic src_match;

    assign src_match = (x_dst_reg_i == d_src_reg_1_i) ||
                       (d_uses_src_2_i && (x_dst_reg_i == d_src_reg_2_i));

    assign lu_o = is_load(x_opcode_i) && (x_dst_reg_i != '0) && src_match;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: per-cycle hold/bubble control for the
// inter-stage flops plus a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import core_pkg::*;
#(
    parameter int REDIRECT_CYCLES = 1,
    parameter int CNT_W           = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] d_src_reg_1,
    input  logic [REG_W-1:0] d_src_reg_2,
    input  logic             d_uses_src_2,
    input  logic [OPC_W-1:0] x_opcode,
    input  logic [REG_W-1:0] x_dst_reg,
    input  logic             x_redirect,
    input  logic             m_mem_req,
    input  logic             dcache_ready,
    output logic             f_hold,
    output logic             d_hold,
    output logic             f2d_flush,
    output logic             d2x_bubble,
    output logic             x_hold,
    output logic             m2w_bubble,
    output logic [1:0]       busy_state,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int              RCNT_W    = 3;
    localparam logic [RCNT_W-1:0] RC_RELOAD = RCNT_W'(REDIRECT_CYCLES - 1);

    seq_state_e       state_q, state_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic lu, mw;
    logic f_hold_c, d_hold_c, f2d_flush_c, d2x_bubble_c, x_hold_c, m2w_bubble_c;

    hazard_detect u_hazard_detect (
        .x_opcode_i     (x_opcode),
        .x_dst_reg_i    (x_dst_reg),
        .d_src_reg_1_i  (d_src_reg_1),
        .d_src_reg_2_i  (d_src_reg_2),
        .d_uses_src_2_i (d_uses_src_2),
        .lu_o           (lu)
    );

    assign mw = m_mem_req && !dcache_ready;

    always_comb begin
        f_hold_c     = 1'b0;
        d_hold_c     = 1'b0;
        f2d_flush_c  = 1'b0;
        d2x_bubble_c = 1'b0;
        x_hold_c     = 1'b0;
        m2w_bubble_c = 1'b0;
        state_d      = state_q;
        rcnt_d       = rcnt_q;

        if (mw) begin
            // A held branch in X re-presents itself, so x_redirect is dropped here.
            f_hold_c     = 1'b1;
            d_hold_c     = 1'b1;
            x_hold_c     = 1'b1;
            m2w_bubble_c = 1'b1;
            state_d      = ST_MEM_WAIT;
        end else if (x_redirect) begin
            f2d_flush_c  = 1'b1;
            d2x_bubble_c = 1'b1;
            if (REDIRECT_CYCLES > 1) begin
                state_d = ST_REDIRECT;
                rcnt_d  = RC_RELOAD;
            end else begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_REDIRECT) begin
            f2d_flush_c  = 1'b1;
            d2x_bubble_c = 1'b1;
            rcnt_d       = rcnt_q - RCNT_W'(1);
            state_d      = (rcnt_q <= RCNT_W'(1)) ? ST_RUN : ST_REDIRECT;
        end else begin
            // RUN, or MEM_WAIT on its completing cycle: ordinary load-use rules.
            if (lu) begin
                f_hold_c     = 1'b1;
                d_hold_c     = 1'b1;
                d2x_bubble_c = 1'b1;
            end
            state_d = ST_RUN;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if ((f_hold_c || x_hold_c) && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            rcnt_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            stall_q <= stall_d;
        end
    end

    // Every output reads 0 while reset is held, even with hazards on the inputs.
    assign f_hold       = f_hold_c     && !reset;
    assign d_hold       = d_hold_c     && !reset;
    assign f2d_flush    = f2d_flush_c  && !reset;
    assign d2x_bubble   = d2x_bubble_c && !reset;
    assign x_hold       = x_hold_c     && !reset;
    assign m2w_bubble   = m2w_bubble_c && !reset;
    assign busy_state   = state_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl with a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
    import core_pkg::*;

    localparam int RC    = 3;
    localparam int CW    = 4;
    localparam int SAT   = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [5:0]    d_src_reg_1, d_src_reg_2, x_dst_reg;
    logic          d_uses_src_2, x_redirect, m_mem_req, dcache_ready;
    logic [6:0]    x_opcode;
    logic          f_hold, d_hold, f2d_flush, d2x_bubble, x_hold, m2w_bubble;
    logic [1:0]    busy_state;
    logic [CW-1:0] stall_cycles;

    int checks = 0;
    int passes = 0;

    // Model state: waiting on the cache, remaining flush cycles, stall count.
    bit m_waiting, nx_waiting;
    int m_left, nx_left, m_stall, nx_stall;
    logic [7:0] exp_vec, act_vec;
    logic [CW-1:0] exp_stall;
    logic [CW-1:0] snap;

    pipe_hazard_ctrl #(.REDIRECT_CYCLES(RC), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .d_src_reg_1(d_src_reg_1), .d_src_reg_2(d_src_reg_2), .d_uses_src_2(d_uses_src_2),
        .x_opcode(x_opcode), .x_dst_reg(x_dst_reg), .x_redirect(x_redirect),
        .m_mem_req(m_mem_req), .dcache_ready(dcache_ready),
        .f_hold(f_hold), .d_hold(d_hold), .f2d_flush(f2d_flush), .d2x_bubble(d2x_bubble),
        .x_hold(x_hold), .m2w_bubble(m2w_bubble), .busy_state(busy_state),
        .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_waiting = 0; m_left = 0; m_stall = 0;
    endtask

    // Drives one cycle of inputs and predicts outputs from the behavioural rules.
    task automatic drive(input logic [6:0] op, input logic [5:0] dst, input logic [5:0] s1,
                         input logic [5:0] s2, input logic u2, input logic rd,
                         input logic req, input logic rdy);
        bit mw, lu, fh, dh, fl, bb, xh, mb;
        int busy;
        x_opcode = op; x_dst_reg = dst; d_src_reg_1 = s1; d_src_reg_2 = s2;
        d_uses_src_2 = u2; x_redirect = rd; m_mem_req = req; dcache_ready = rdy;
        mw = req && !rdy;
        lu = (op == OP_LDB || op == OP_LDW) && dst != 0 && (dst == s1 || (u2 && dst == s2));
        {fh, dh, fl, bb, xh, mb} = '0;
        busy = m_waiting ? 1 : (m_left > 0 ? 2 : 0);
        nx_waiting = m_waiting; nx_left = m_left;
        if (mw) begin
            fh = 1; dh = 1; xh = 1; mb = 1; nx_waiting = 1;
        end else if (rd) begin
            fl = 1; bb = 1; nx_waiting = 0; nx_left = RC - 1;
        end else if (!m_waiting && m_left > 0) begin
            fl = 1; bb = 1; nx_left = m_left - 1;
        end else begin
            if (lu) begin fh = 1; dh = 1; bb = 1; end
            nx_waiting = 0; nx_left = 0;
        end
        exp_vec   = {fh, dh, fl, bb, xh, mb, 2'(busy)};
        exp_stall = CW'(m_stall);
        nx_stall  = (fh || xh) ? ((m_stall < SAT) ? m_stall + 1 : SAT) : m_stall;
        #1;
    endtask

    task automatic commit();
        @(posedge clock);
        m_waiting = nx_waiting; m_left = nx_left; m_stall = nx_stall;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(OP_LDW, 6'd5, 6'd5, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clock); @(negedge clock); #1;
        act_vec = {f_hold, d_hold, f2d_flush, d2x_bubble, x_hold, m2w_bubble, busy_state};
        checks++;
        if (act_vec !== 8'h00) $display("FAIL reset_outputs: got %b expected %b", act_vec, 8'h00);
        else passes++;
        checks++;
        if (stall_cycles !== '0) $display("FAIL reset_stall: got %0d expected 0", stall_cycles);
        else passes++;
        drive(OP_BEQ, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
    endtask

    task automatic test_load_use();
        snap = stall_cycles;
        drive(OP_LDW, 6'd5, 6'd5, 6'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        act_vec = {f_hold, d_hold, f2d_flush, d2x_bubble, x_hold, m2w_bubble, busy_state};
        checks++;
        if (act_vec !== 8'b1101_0000) $display("FAIL load_use_hold: got %b expected %b", act_vec, 8'b1101_0000);
        else passes++;
        commit();
        drive(OP_BEQ, 6'd0, 6'd5, 6'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        act_vec = {f_hold, d_hold, f2d_flush, d2x_bubble, x_hold, m2w_bubble, busy_state};
        checks++;
        if (act_vec !== exp_vec) $display("FAIL load_use_release: got %b expected %b", act_vec, exp_vec);
        else passes++;
        checks++;
        if (stall_cycles !== snap + CW'(1)) $display("FAIL load_use_count: got %0d expected %0d", stall_cycles, snap + CW'(1));
        else passes++;
        commit();
    endtask

    task automatic test_false_hazard();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: drive(OP_LDW, 6'd0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
                1: drive(OP_LDB, 6'd5, 6'd3, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0);
                default: drive(OP_STW, 6'd5, 6'd5, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0);
            endcase
            act_vec = {f_hold, d_hold, f2d_flush, d2x_bubble, x_hold, m2w_bubble, busy_state};
            checks++;
            if (act_vec !== 8'h00) $display("FAIL false_hazard_%0d: got %b expected %b", i, act_vec, 8'h00);
            else passes++;
            commit();
        end
    endtask

    task automatic test_cache_miss();
        snap = stall_cycles;
        for (int i = 0; i < 5; i++) begin
            drive(OP_BEQ, 6'd0, 6'd1, 6'd2, 1'b0, 1'b0, i < 4, i >= 3);
            act_vec = {f_hold, d_hold, f2d_flush, d2x_bubble, x_hold, m2w_bubble, busy_state};
            checks++;
            if (act_vec !== exp_vec) $display("FAIL cache_miss_cyc%0d: got %b expected %b", i, act_vec, exp_vec);
            else passes++;
            checks++;
            if (stall_cycles !== exp_stall) $display("FAIL cache_miss_stall%0d: got %0d expected %0d", i, stall_cycles, exp_stall);
            else passes++;
            commit();
        end
        checks++;
        if (stall_cycles !== snap + CW'(3)) $display("FAIL cache_miss_total: got %0d expected %0d", stall_cycles, snap + CW'(3));
        else passes++;
        checks++;
        if (busy_state !== 2'd0) $display("FAIL cache_miss_state: got %0d expected 0", busy_state);
        else passes++;
    endtask

    task automatic test_redirect_during_mw();
        for (int i = 0; i < 6; i++) begin
            drive(OP_JUMP, 6'd0, 6'd1, 6'd2, 1'b0, i < 3, i < 3, i >= 2);
            act_vec = {f_hold, d_hold, f2d_flush, d2x_bubble, x_hold, m2w_bubble, busy_state};
            checks++;
            if (act_vec !== exp_vec) $display("FAIL redir_mw_cyc%0d: got %b expected %b", i, act_vec, exp_vec);
            else passes++;
            commit();
        end
    endtask

    task automatic test_redirect_lu();
        for (int i = 0; i < 5; i++) begin
            drive(OP_LDB, 6'd7, 6'd7, 6'd0, 1'b0, i == 0, 1'b0, 1'b0);
            act_vec = {f_hold, d_hold, f2d_flush, d2x_bubble, x_hold, m2w_bubble, busy_state};
            checks++;
            if (act_vec !== exp_vec) $display("FAIL redir_lu_cyc%0d: got %b expected %b", i, act_vec, exp_vec);
            else passes++;
            if (i < 3) begin
                checks++;
                if (f2d_flush !== 1'b1 || f_hold !== 1'b0)
                    $display("FAIL redir_lu_flush%0d: got flush=%b hold=%b expected flush=1 hold=0", i, f2d_flush, f_hold);
                else passes++;
            end
            commit();
        end
    endtask

    task automatic test_reset_mid_wait();
        drive(OP_BEQ, 6'd0, 6'd1, 6'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        commit();
        drive(OP_BEQ, 6'd0, 6'd1, 6'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (busy_state !== 2'd1) $display("FAIL mid_wait_state: got %0d expected 1", busy_state);
        else passes++;
        reset = 1'b1;
        #1;
        act_vec = {f_hold, d_hold, f2d_flush, d2x_bubble, x_hold, m2w_bubble, busy_state};
        checks++;
        if (act_vec !== 8'h00) $display("FAIL async_reset_outputs: got %b expected %b", act_vec, 8'h00);
        else passes++;
        checks++;
        if (stall_cycles !== '0) $display("FAIL async_reset_stall: got %0d expected 0", stall_cycles);
        else passes++;
        reset = 1'b0;
        model_reset();
        drive(OP_BEQ, 6'd0, 6'd1, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        act_vec = {f_hold, d_hold, f2d_flush, d2x_bubble, x_hold, m2w_bubble, busy_state};
        checks++;
        if (act_vec !== exp_vec) $display("FAIL after_reset: got %b expected %b", act_vec, exp_vec);
        else passes++;
        commit();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            drive(OP_STB, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (stall_cycles !== exp_stall) $display("FAIL sat_cyc%0d: got %0d expected %0d", i, stall_cycles, exp_stall);
            else passes++;
            commit();
        end
        checks++;
        if (stall_cycles !== CW'(SAT)) $display("FAIL sat_final: got %0d expected %0d", stall_cycles, SAT);
        else passes++;
        drive(OP_STB, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        commit();
    endtask

    task automatic test_random();
        logic [6:0] ops [5];
        ops = '{OP_LDB, OP_LDW, OP_STW, OP_BEQ, OP_JUMP};
        for (int i = 0; i < 400; i++) begin
            drive(ops[$urandom_range(0, 4)], 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
                  6'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            act_vec = {f_hold, d_hold, f2d_flush, d2x_bubble, x_hold, m2w_bubble, busy_state};
            checks++;
            if (act_vec !== exp_vec) $display("FAIL random_cyc%0d: got %b expected %b", i, act_vec, exp_vec);
            else passes++;
            checks++;
            if (stall_cycles !== exp_stall) $display("FAIL random_stall%0d: got %0d expected %0d", i, stall_cycles, exp_stall);
            else passes++;
            commit();
        end
    endtask

    initial begin
        model_reset();
        @(negedge clock);
        test_reset();
        test_load_use();
        test_false_hazard();
        test_cache_miss();
        test_redirect_during_mw();
        test_redirect_lu();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the five-stage core (F, D, X, M, W).
- Each cycle it decides whether each inter-stage flop (f2d, d2x, x2m, m2w) loads, holds or takes a bubble.
- Sources: load-use hazards, taken branches/jumps resolved in X, and data-cache misses in M.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- REDIRECT_CYCLES, 1, total cycles f2d/d2x are bubbled after a taken redirect (1..4).
- CNT_W, 32, width of stall_cycles counter.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- d_src_reg_1  in  6  decode-stage source register 1 index
- d_src_reg_2  in  6  decode-stage source register 2 index
- d_uses_src_2  in  1  decode instruction reads src 2
- x_opcode  in  7  execute-stage opcode
- x_dst_reg  in  6  execute-stage destination index
- x_redirect  in  1  X resolved a taken branch/jump this cycle
- m_mem_req  in  1  M-stage load/store active
- dcache_ready  in  1  data cache completes M access this cycle
- f_hold  out  1  PC and f2d hold
- d_hold  out  1  f2d hold (decode instruction retained)
- f2d_flush  out  1  f2d loads a bubble
- d2x_bubble  out  1  d2x loads a bubble; ORed with reset into the d2x reset input
- x_hold  out  1  d2x and x2m hold
- m2w_bubble  out  1  m2w loads a bubble
- busy_state  out  2  current FSM state, for debug
- stall_cycles  out  CNT_W  count of cycles with any hold asserted

Behaviour:
- FSM states: RUN=0, MEM_WAIT=1, REDIRECT=2. The state register and the redirect counter are asynchronously reset to RUN / 0.
- Reset values: all hold/bubble outputs 0, busy_state=0, stall_cycles=0.
- Hold/bubble outputs are combinational from state and inputs (same-cycle effect). State and counter update on posedge clock.
- Load-use detection (lu):
  - lu = x_opcode is OP_LDB or OP_LDW, and x_dst_reg != 0, and the load destination matches a used decode source.
  - "Matches a used source" means x_dst_reg == d_src_reg_1, or (d_uses_src_2 and x_dst_reg == d_src_reg_2).
- Memory wait (mw): mw = m_mem_req and not dcache_ready.
- Priority per cycle, highest first: MEM_WAIT/mw, then redirect, then lu.
- mw, in any state:
  - f_hold = d_hold = x_hold = 1 and m2w_bubble = 1.
  - x_redirect is ignored, because the held branch re-presents itself once the wait clears.
  - Next state is MEM_WAIT.
- MEM_WAIT with dcache_ready = 1: no holds, and the normal RUN rules apply this cycle. Next state is RUN, or REDIRECT if x_redirect.
- x_redirect while not mw:
  - f2d_flush = 1 and d2x_bubble = 1.
  - lu is ignored.
  - If REDIRECT_CYCLES > 1, go to REDIRECT with counter = REDIRECT_CYCLES-1.
- REDIRECT state: f2d_flush = d2x_bubble = 1 and the counter decrements each cycle. At counter 1 the next state is RUN. A new x_redirect reloads the counter. mw overrides as above and preserves the counter.
- lu in RUN, with no redirect and no mw: f_hold = d_hold = 1 and d2x_bubble = 1 for exactly one cycle. The hazard clears naturally once the load advances to M. No state change.
- stall_cycles increments when f_hold or x_hold is 1, and saturates at all-ones.
- If reset is asserted mid-MEM_WAIT or mid-REDIRECT, the FSM returns to RUN immediately. All outputs are 0 while reset is held.

Decomposition:
- Shared package core_pkg holds:
  - opcode constants: OP_LDB=7'h11, OP_LDW=7'h12, OP_STB=7'h13, OP_STW=7'h14, OP_BEQ=7'h30, OP_JUMP=7'h31;
  - REG_W=6 and OPC_W=7;
  - the FSM state encoding.
- One sub-module, hazard_detect: combinational lu comparator, reusable by the forwarding unit.

Test Plan:
- Load-use: x_opcode=OP_LDW, x_dst_reg=5, d_src_reg_1=5 -> f_hold=d_hold=d2x_bubble=1 for exactly 1 cycle, stall_cycles +1.
- False hazards:
  - x_dst_reg=0 with d_src_reg_1=0 -> no stall;
  - d_src_reg_2=5, d_uses_src_2=0, x_dst_reg=5 -> no stall.
- Cache miss: m_mem_req=1, dcache_ready=0 for 3 cycles then 1 -> x_hold=m2w_bubble=1 for 3 cycles, busy_state=1, stall_cycles=3, then RUN.
- Simultaneous events: x_redirect=1 during mw -> no flush while waiting. On the dcache_ready cycle, f2d_flush=d2x_bubble=1.
- REDIRECT_CYCLES=3 with x_redirect pulse -> f2d_flush asserted for 3 consecutive cycles, with lu concurrently asserted and ignored.
- Async reset pulse mid-MEM_WAIT (between clock edges) -> busy_state=0 and all holds 0 immediately. stall_cycles=0 and saturation at all-ones is checked with CNT_W=4.
